// File: rtl/uart_tx_sched.sv
// Two-requester round-robin byte scheduler feeding a UART transmitter.
// Handles launch, busy handshake with timeout, frame counting and the inter-frame gap.
module uart_tx_sched #(
   parameter int GAP_CYCLES   = 1250,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [7:0]  req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [7:0]  req1_data,
   output logic        req1_ready,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   output logic        grant_id,
   output logic [2:0]  sched_state,
   output logic [15:0] frame_count,
   output logic        err_timeout
);

   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int BT_W  = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } state_t;

   state_t             state_reg, state_next;
   logic [7:0]         hold_reg;
   logic               grant_reg;
   logic [15:0]        frame_count_reg;
   logic               err_reg;
   logic [GAP_W-1:0]   gap_cnt_reg;
   logic [BT_W-1:0]    busy_cnt_reg;
   logic               busy_early_reg;

   logic               pick1;
   logic               accept;
   logic               timeout;
   logic               frame_done;

   // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
   assign pick1      = req1_valid && (!req0_valid || (grant_reg == 1'b0));
   assign req0_ready = (state_reg == IDLE) && !rst && req0_valid && !pick1;
   assign req1_ready = (state_reg == IDLE) && !rst && pick1;
   assign accept     = req0_ready || req1_ready;

   assign tx_start    = (state_reg == LAUNCH);
   assign tx_data     = hold_reg;
   assign grant_id    = grant_reg;
   assign sched_state = state_reg;
   assign frame_count = frame_count_reg;
   assign err_timeout = err_reg;

   always_comb begin
      state_next = state_reg;
      timeout    = 1'b0;
      frame_done = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) state_next = LAUNCH;
         end
         LAUNCH: begin
            state_next = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy || busy_early_reg) begin
               state_next = WAIT_DONE;
            end else if (busy_cnt_reg == BT_W'(BUSY_TIMEOUT - 1)) begin
               timeout    = 1'b1;
               state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               frame_done = 1'b1;
               state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
         end
         GAP: begin
            if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         hold_reg        <= 8'h00;
         grant_reg       <= 1'b1;
         frame_count_reg <= 16'h0000;
         err_reg         <= 1'b0;
         gap_cnt_reg     <= '0;
         busy_cnt_reg    <= '0;
         busy_early_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            hold_reg  <= req1_ready ? req1_data : req0_data;
            grant_reg <= req1_ready;
         end
         // A transmitter that is already busy during launch counts as seen on the first wait cycle.
         busy_early_reg <= (state_reg == LAUNCH) && tx_busy;
         if (state_reg == WAIT_BUSY) busy_cnt_reg <= busy_cnt_reg + BT_W'(1);
         else                        busy_cnt_reg <= '0;
         if (state_reg == GAP) gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
         else                  gap_cnt_reg <= '0;
         if (frame_done) frame_count_reg <= frame_count_reg + 16'd1;
         if (timeout)    err_reg <= 1'b1;
      end
   end

endmodule
